// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_unit sequencer.
package rsa_pkg;

  localparam int unsigned WIDTH     = 7;
  localparam int unsigned TMO_W     = 12;
  localparam int unsigned TMO_LIMIT = 4000;
  localparam int unsigned EOC_BLANK = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_CAPT = 2'd3
  } rsa_state_e;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_BUSY = 1;
  localparam int unsigned STAT_ERRP = 2;
  localparam int unsigned STAT_ERRT = 3;
  localparam int unsigned STAT_IRQ  = 4;

  localparam int unsigned ACT_START = 0;
  localparam int unsigned ACT_ABORT = 1;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_ACTIONS = 3'd1,
    REG_P       = 3'd2,
    REG_E       = 3'd3,
    REG_M       = 3'd4,
    REG_CONST   = 3'd5,
    REG_RESULT  = 3'd6,
    REG_RSVD    = 3'd7
  } rsa_reg_e;

  // Operand set handed to the core.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] k;
  } rsa_ops_t;

  // Decode a register-bank write into {clr_status, abort, start} pulses.
  function automatic logic [2:0] act_decode(input logic wr_vld, input rsa_reg_e addr,
                                            input logic [7:0] data);
    logic [2:0] pulses;
    pulses = 3'b000;
    if (wr_vld && addr == REG_ACTIONS) begin
      pulses[0] = data[ACT_START];
      pulses[1] = data[ACT_ABORT];
    end
    if (wr_vld && addr == REG_STATUS) pulses[2] = 1'b1;
    return pulses;
  endfunction

endpackage

// File: rtl/rsa_seq_tmo.sv
// Saturating run-cycle counter with eoc-blank and timeout compares.
module rsa_seq_tmo #(
  parameter int unsigned TMO_W     = 12,
  parameter int unsigned TMO_LIMIT = 4000,
  parameter int unsigned EOC_BLANK = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic blank_c,
  output logic limit_c
);

  logic [TMO_W-1:0] cnt_q;

  // Count RUN cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // Blank window covers the first EOC_BLANK RUN cycles; limit flags the last allowed one.
  always_comb begin
    blank_c = (cnt_q < TMO_W'(EOC_BLANK));
    limit_c = (cnt_q >= TMO_W'(TMO_LIMIT - 1));
  end

endmodule

// File: rtl/rsa_seq.sv
// Sequencer: validates and latches operands, runs rsa_unit under timeout, captures C.
module rsa_seq
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_status,
  input  logic [WIDTH-1:0] cfg_p,
  input  logic [WIDTH-1:0] cfg_e,
  input  logic [WIDTH-1:0] cfg_m,
  input  logic [WIDTH-1:0] cfg_const,
  output logic             rsa_en,
  output logic             rsa_rst_n,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_const,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_c,
  output logic [WIDTH-1:0] result,
  output logic             result_vld,
  output logic [7:0]       status,
  output logic             irq
);

  rsa_state_e st_q, st_d;
  rsa_ops_t   ops_q;
  logic       busy_q, done_q, errp_q, errt_q;
  logic       done_d, errp_d, errt_d;
  logic       blank_c, limit_c;
  logic       p_bad_c, req_c, accept_c, perr_c, eoc_ok_c, capt_c, tmo_c, fin_c;

  rsa_seq_tmo #(
    .TMO_W    (TMO_W),
    .TMO_LIMIT(TMO_LIMIT),
    .EOC_BLANK(EOC_BLANK)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (st_q == ST_LOAD),
    .inc    (st_q == ST_RUN),
    .blank_c(blank_c),
    .limit_c(limit_c)
  );

  // Qualifying events; abort overrides every other transition.
  always_comb begin
    p_bad_c  = !cfg_p[0] || (cfg_p < WIDTH'(3));
    req_c    = (st_q == ST_IDLE) && start && !abort;
    accept_c = req_c && !p_bad_c;
    perr_c   = req_c && p_bad_c;
    eoc_ok_c = rsa_eoc && !blank_c;
    capt_c   = (st_q == ST_RUN) && !abort && eoc_ok_c;
    tmo_c    = (st_q == ST_RUN) && !abort && !eoc_ok_c && limit_c;
    fin_c    = (st_q == ST_CAPT) && !abort;
  end

  // Next state and sticky status bits (a set beats a same-cycle clear).
  always_comb begin
    st_d   = st_q;
    done_d = done_q;
    errp_d = errp_q;
    errt_d = errt_q;
    case (st_q)
      ST_IDLE: if (accept_c) st_d = ST_LOAD;
      ST_LOAD: st_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort || tmo_c) st_d = ST_IDLE;
        else if (capt_c)    st_d = ST_CAPT;
      end
      ST_CAPT: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (clr_status || accept_c) begin
      done_d = 1'b0;
      errp_d = 1'b0;
      errt_d = 1'b0;
    end
    if (fin_c)  done_d = 1'b1;
    if (perr_c) errp_d = 1'b1;
    if (tmo_c)  errt_d = 1'b1;
  end

  // State, core control, shadows, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      rsa_en     <= 1'b0;
      rsa_rst_n  <= 1'b0;
      ops_q      <= '0;
      result     <= '0;
      result_vld <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      errp_q     <= 1'b0;
      errt_q     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      st_q       <= st_d;
      rsa_en     <= (st_d == ST_RUN);
      rsa_rst_n  <= (st_d == ST_RUN);
      busy_q     <= (st_d != ST_IDLE);
      done_q     <= done_d;
      errp_q     <= errp_d;
      errt_q     <= errt_d;
      irq        <= done_d | errp_d | errt_d;
      result_vld <= capt_c;
      if (capt_c)   result <= rsa_c;
      if (accept_c) ops_q  <= '{p: cfg_p, e: cfg_e, m: cfg_m, k: cfg_const};
    end
  end

  // Drive core operands and the status word from registers.
  always_comb begin
    rsa_p     = ops_q.p;
    rsa_e     = ops_q.e;
    rsa_m     = ops_q.m;
    rsa_const = ops_q.k;
    status            = 8'h00;
    status[STAT_DONE] = done_q;
    status[STAT_BUSY] = busy_q;
    status[STAT_ERRP] = errp_q;
    status[STAT_ERRT] = errt_q;
    status[STAT_IRQ]  = irq;
  end

endmodule

// File: tb/tb_rsa_seq.sv
// Scoreboard bench for rsa_seq with a behavioural rsa_unit stub.
module tb_rsa_seq;
  import rsa_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0, abort = 1'b0, clr_status = 1'b0;
  logic [WIDTH-1:0] cfg_p = '0, cfg_e = '0, cfg_m = '0, cfg_const = '0;
  logic             rsa_en, rsa_rst_n, rsa_eoc, result_vld, irq;
  logic [WIDTH-1:0] rsa_p, rsa_e, rsa_m, rsa_const, rsa_c, result;
  logic [7:0]       status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int res; int cyc; } exp_t;
  exp_t sbq[$];

  // Stub core: eoc is a stale level for the first stub_stale RUN cycles, then rises at stub_delay.
  int               stub_delay = -1;
  int               stub_stale = 0;
  int               en_cnt = 0;
  logic [WIDTH-1:0] stub_c = '0;

  rsa_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clr_status(clr_status),
    .cfg_p(cfg_p), .cfg_e(cfg_e), .cfg_m(cfg_m), .cfg_const(cfg_const),
    .rsa_en(rsa_en), .rsa_rst_n(rsa_rst_n),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_eoc(rsa_eoc), .rsa_c(rsa_c), .result(result), .result_vld(result_vld),
    .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rsa_rst_n)  en_cnt <= 0;
    else if (rsa_en) en_cnt <= en_cnt + 1;
  end

  assign rsa_eoc = (en_cnt < stub_stale) || (stub_delay >= 0 && en_cnt >= stub_delay);
  assign rsa_c   = stub_c;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every result_vld pulse must match the oldest expected capture.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && result_vld) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result_vld", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("result", int'(result), e.res);
        chk("result_vld_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference: first RUN cycle index at/after the blank window where eoc is high, -1 on timeout.
  function automatic int exp_q(input int delay, input int stale);
    for (int k = int'(EOC_BLANK); k < int'(TMO_LIMIT); k++)
      if (k < stale || (delay >= 0 && k >= delay)) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; queue the expected capture when the job should complete.
  task automatic issue(input logic [WIDTH-1:0] p, e, m, k, c, input int delay, stale,
                       input bit expect_done);
    int   q;
    exp_t x;
    cfg_p = p; cfg_e = e; cfg_m = m; cfg_const = k;
    stub_c = c; stub_delay = delay; stub_stale = stale;
    q = exp_q(delay, stale);
    if (expect_done && p[0] && p >= 7'd3 && q >= 0) begin
      x.res = int'(c);
      x.cyc = cyc + 3 + q;
      sbq.push_back(x);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (status[STAT_BUSY] && n < budget) begin
      tick();
      n++;
    end
    if (status[STAT_BUSY]) chk("idle_wait_budget", 1, 0);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] p, c, last_res;
    int               q, en_cycles, en_rise, base;

    // Asynchronous reset applied between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsa_en", int'(rsa_en), 0);
    chk("rst_rsa_rst_n", int'(rsa_rst_n), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rsa_p", int'(rsa_p), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Normal job: P=33 E=7 M=4, eoc 20 cycles after enable, C=0x10.
    issue(7'd33, 7'd7, 7'd4, 7'd5, 7'h10, 20, 0, 1'b1);
    chk("load_rsa_rst_n", int'(rsa_rst_n), 0);
    chk("load_rsa_en", int'(rsa_en), 0);
    chk("load_busy", int'(status[STAT_BUSY]), 1);
    chk("load_rsa_p", int'(rsa_p), 33);
    chk("load_rsa_e", int'(rsa_e), 7);
    chk("load_rsa_m", int'(rsa_m), 4);
    tick();
    chk("run_rsa_en", int'(rsa_en), 1);
    chk("run_rsa_rst_n", int'(rsa_rst_n), 1);
    wait_idle(100);
    chk("normal_status", int'(status), 'h11);
    chk("normal_irq", int'(irq), 1);
    chk("normal_result", int'(result), 16);

    // Stale eoc for the blank window, then re-asserted; operands scribbled mid-run.
    issue(7'd45, 7'd3, 7'd9, 7'd1, 7'h2A, 20, int'(EOC_BLANK), 1'b1);
    repeat (3) tick();
    cfg_p = 7'd2; cfg_e = 7'd0; cfg_m = 7'd127;
    tick();
    chk("shadow_p_stable", int'(rsa_p), 45);
    chk("shadow_m_stable", int'(rsa_m), 9);
    wait_idle(100);
    chk("stale_status", int'(status), 'h11);

    // eoc held high throughout: first qualifying sample is at the end of the blank window.
    issue(7'd3, 7'd1, 7'd2, 7'd3, 7'h55, 0, 0, 1'b1);
    wait_idle(50);
    chk("blank_edge_result", int'(result), 'h55);

    // Randomized jobs, some with a start injected while busy.
    for (int j = 0; j < 12; j++) begin
      p = 7'($urandom_range(1, 63) * 2 + 1);
      c = 7'($urandom);
      issue(p, 7'($urandom), 7'($urandom), 7'($urandom), c,
            int'($urandom_range(0, 40)), int'($urandom_range(0, 4)), 1'b1);
      if (j % 2 == 0) begin
        repeat ($urandom_range(0, 4)) tick();
        if (status[STAT_BUSY]) begin
          cfg_p = 7'd99;
          start = 1'b1;
          tick();
          start = 1'b0;
          chk("busy_start_ignored_p", int'(rsa_p), int'(p));
        end
      end
      wait_idle(100);
      chk("rand_status", int'(status), 'h11);
      chk("rand_result", int'(result), int'(c));
    end

    // clr_status in the CAPT cycle: done still ends up set.
    q = exp_q(10, 0);
    base = cyc;
    issue(7'd21, 7'd5, 7'd6, 7'd7, 7'h33, 10, 0, 1'b1);
    while (cyc < base + 3 + q) tick();
    pulse_clr();
    wait_idle(10);
    chk("clr_vs_done_status", int'(status), 'h11);

    // Parameter errors: even modulus and modulus below 3.
    pulse_clr();
    chk("clr_status", int'(status), 0);
    chk("clr_irq", int'(irq), 0);
    issue(7'd32, 7'd7, 7'd4, 7'd5, 7'h11, 0, 0, 1'b1);
    en_rise = int'(rsa_en);
    repeat (10) begin tick(); en_rise += int'(rsa_en); end
    chk("perr32_status", int'(status), 'h14);
    chk("perr32_rsa_en", en_rise, 0);
    pulse_clr();
    chk("clr2_status", int'(status), 0);
    issue(7'd1, 7'd7, 7'd4, 7'd5, 7'h11, 0, 0, 1'b1);
    en_rise = int'(rsa_en);
    repeat (10) begin tick(); en_rise += int'(rsa_en); end
    chk("perr1_status", int'(status), 'h14);
    chk("perr1_rsa_en", en_rise, 0);
    chk("perr_irq", int'(irq), 1);

    // Timeout: eoc never arrives.
    last_res = result;
    issue(7'd33, 7'd7, 7'd4, 7'd5, 7'h7F, -1, 0, 1'b1);
    en_cycles = 0;
    for (int n = 0; n < int'(TMO_LIMIT) + 50 && status[STAT_BUSY]; n++) begin
      en_cycles += int'(rsa_en);
      tick();
    end
    chk("tmo_run_cycles", en_cycles, int'(TMO_LIMIT));
    chk("tmo_status", int'(status), 'h18);
    chk("tmo_rsa_en", int'(rsa_en), 0);
    chk("tmo_result_kept", int'(result), int'(last_res));

    // Abort at RUN cycle 5.
    issue(7'd33, 7'd7, 7'd4, 7'd5, 7'h44, 20, 0, 1'b0);
    repeat (6) tick();
    chk("pre_abort_rsa_en", int'(rsa_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rsa_en", int'(rsa_en), 0);
    chk("abort_status", int'(status), 0);
    repeat (25) tick();
    chk("abort_result_kept", int'(result), int'(last_res));

    // start and abort together in IDLE: stays idle.
    cfg_p = 7'd33;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(status[STAT_BUSY]), 0);
    tick();
    chk("start_abort_rsa_en", int'(rsa_en), 0);

    chk("scoreboard_drained", sbq.size(), 0);

    // Asynchronous reset mid-RUN.
    issue(7'd77, 7'd7, 7'd4, 7'd5, 7'h22, 30, 0, 1'b0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsa_en", int'(rsa_en), 0);
    chk("midrst_rsa_rst_n", int'(rsa_rst_n), 0);
    chk("midrst_status", int'(status), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_rsa_p", int'(rsa_p), 0);
    chk("midrst_irq", int'(irq), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
